// File: rtl/seg_pkg.sv
// Shared constants, FSM states and 7-segment/BCD helpers for the scan display driver.
package seg_pkg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned BIN_W    = 7;
    localparam int unsigned BCD_W    = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned CONV_CYC = 7;
    localparam int unsigned CYC_W    = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [BIN_W-1:0] BIN_MAX   = 7'd99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_HI = 2'd1,
        CONV_LO = 2'd2,
        COMMIT  = 2'd3
    } conv_state_e;

    // {g,f,e,d,c,b,a}, active high; anything above 9 is dark
    function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [BIN_W-1:0] sat99(input logic [BIN_W-1:0] v);
        return (v > BIN_MAX) ? BIN_MAX : v;
    endfunction

    // Double-dabble correction: nibbles >=5 get +3 before the next shift
    function automatic logic [2*BCD_W-1:0] bcd_add3(input logic [2*BCD_W-1:0] b);
        logic [2*BCD_W-1:0] r;
        r = b;
        if (r[BCD_W-1:0] >= 4'd5)
            r[BCD_W-1:0] = r[BCD_W-1:0] + 4'd3;
        if (r[2*BCD_W-1:BCD_W] >= 4'd5)
            r[2*BCD_W-1:BCD_W] = r[2*BCD_W-1:BCD_W] + 4'd3;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add converter: 7-bit binary (<=99) to two BCD digits, one bit per cycle.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones
);

    logic [BIN_W-1:0]   r_bin;
    logic [2*BCD_W-1:0] r_bcd;
    logic [CYC_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*BCD_W-1:0] w_adj;

    always_comb begin
        w_adj = bcd_add3(r_bcd);
    end

    // Start performs the first iteration directly on the operand; six more follow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_bcd  <= {{(2*BCD_W-1){1'b0}}, i_bin[BIN_W-1]};
            r_bin  <= {i_bin[BIN_W-2:0], 1'b0};
            r_cnt  <= CYC_W'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_bcd <= {w_adj[2*BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt + CYC_W'(1);
            if (r_cnt == CYC_W'(CONV_CYC - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_tens = r_bcd[2*BCD_W-1:BCD_W];
    assign o_ones = r_bcd[BCD_W-1:0];

endmodule

// File: rtl/seg_scan_driver.sv
// Converts two binary fields to BCD and scans four common-cathode 7-seg digits with blanking gaps.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens the leftmost digit when the hi tens digit is 0.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 8,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BIN_W-1:0]   hi_val,
    input  logic [BIN_W-1:0]   lo_val,
    input  logic               load,
    input  logic [DIGITS-1:0]  digit_mask,
    output logic               busy,
    output logic [SEG_W-1:0]   seg,
    output logic [DIGITS-1:0]  dig
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DIGITS);

    conv_state_e       r_state;
    conv_state_e       w_state_nxt;
    logic [CYC_W-1:0]  r_cyc;
    logic [BIN_W-1:0]  r_op_hi;
    logic [BIN_W-1:0]  r_op_lo;
    logic              r_pend;
    logic [BIN_W-1:0]  r_pend_hi;
    logic [BIN_W-1:0]  r_pend_lo;
    logic [BCD_W-1:0]  r_hi_tens;
    logic [BCD_W-1:0]  r_hi_ones;
    logic [BCD_W-1:0]  r_digit [DIGITS];
    logic              r_busy;

    logic              w_conv_start;
    logic [BIN_W-1:0]  w_conv_bin;
    logic              w_conv_done;
    logic [BCD_W-1:0]  w_tens;
    logic [BCD_W-1:0]  w_ones;
    logic              w_cap_hi;
    logic              w_commit;
    logic              w_load_idle;
    logic              w_restart;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_lz_blank;
    logic              w_show;
    logic [SEG_W-1:0]  r_seg;
    logic [DIGITS-1:0] r_dig;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_conv_start),
        .i_bin   (w_conv_bin),
        .o_done  (w_conv_done),
        .o_tens  (w_tens),
        .o_ones  (w_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == IDLE))
                r_cyc <= '0;
            else
                r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    // A load during COMMIT (or a waiting pending slot) restarts instead of idling
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load) w_state_nxt = CONV_HI;
            CONV_HI: if (r_cyc == CYC_W'(CONV_CYC - 1)) w_state_nxt = CONV_LO;
            CONV_LO: if (r_cyc == CYC_W'(CONV_CYC - 1)) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = (r_pend || load) ? CONV_HI : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_conv_start = 1'b0;
        w_conv_bin   = r_op_hi;
        w_cap_hi     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            CONV_HI: w_conv_start = (r_cyc == '0);
            CONV_LO: begin
                w_conv_start = (r_cyc == '0);
                w_conv_bin   = r_op_lo;
                w_cap_hi     = w_conv_done;
            end
            COMMIT:  w_commit = 1'b1;
            default: ;
        endcase
    end

    assign w_load_idle = load && (r_state == IDLE);
    assign w_restart   = (r_state == COMMIT) && (r_pend || load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_hi   <= '0;
            r_op_lo   <= '0;
            r_pend    <= 1'b0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            if (w_load_idle) begin
                r_op_hi <= sat99(hi_val);
                r_op_lo <= sat99(lo_val);
            end else if (w_restart) begin
                r_op_hi <= load ? sat99(hi_val) : r_pend_hi;
                r_op_lo <= load ? sat99(lo_val) : r_pend_lo;
            end
            if (w_restart) begin
                r_pend <= 1'b0;
            end else if (load && (r_state != IDLE)) begin
                r_pend    <= 1'b1;
                r_pend_hi <= sat99(hi_val);
                r_pend_lo <= sat99(lo_val);
            end
        end
    end

    // Hi result is parked until the lo field finishes so all four digits change together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_tens <= '0;
            r_hi_ones <= '0;
            for (int i = 0; i < int'(DIGITS); i++)
                r_digit[i] <= '0;
        end else begin
            if (w_cap_hi) begin
                r_hi_tens <= w_tens;
                r_hi_ones <= w_ones;
            end
            if (w_commit) begin
                r_digit[3] <= r_hi_tens;
                r_digit[2] <= r_hi_ones;
                r_digit[1] <= w_tens;
                r_digit[0] <= w_ones;
            end
        end
    end

    assign w_cnt_nxt = (r_cnt == CNT_W'(SCAN_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
    assign w_idx_nxt = (r_cnt == CNT_W'(SCAN_DIV - 1)) ? r_idx - IDX_W'(1) : r_idx;

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz_blank = (w_idx_nxt == IDX_W'(3)) && (r_digit[3] == '0);
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_show = (w_cnt_nxt >= CNT_W'(BLANK_CYC)) && digit_mask[w_idx_nxt] && !w_lz_blank;

    // Outputs are registered from the next scan position so they line up with the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= IDX_W'(3);
            r_seg <= SEG_BLANK;
            r_dig <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
            r_seg <= w_show ? seg_encode(r_digit[w_idx_nxt]) : SEG_BLANK;
            r_dig <= w_show ? (DIGITS'(1) << w_idx_nxt) : '0;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign dig  = r_dig;

endmodule
